// File: rtl/bps_pkg.sv
// Shared opcode values, FSM state encoding and default bus widths for the BP-S sequencer.
package bps_pkg;

  localparam int unsigned OPCODE_W_DEF = 3;

  localparam logic [2:0] OP_IDLE     = 3'd0;
  localparam logic [2:0] OP_LOAD     = 3'd1;
  localparam logic [2:0] OP_DOWN     = 3'd2;
  localparam logic [2:0] OP_UP       = 3'd3;
  localparam logic [2:0] OP_STORE_DN = 3'd4;
  localparam logic [2:0] OP_STORE_UP = 3'd5;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_LOAD_W,
    S_DOWN,
    S_DOWN_W,
    S_ST_DN,
    S_ST_DN_W,
    S_UP,
    S_UP_W,
    S_ST_UP,
    S_ST_UP_W,
    S_EXEC,
    S_EXEC_W
  } state_e;

endpackage

// File: rtl/bps_stall_agg.sv
// Reduces per-engine stall and convergence flags over the latched engine mask;
// disabled engines never block and always count as converged.
module bps_stall_agg #(
  parameter int unsigned NUM_ENGINES = 4
) (
  input  logic [NUM_ENGINES-1:0] mask,
  input  logic [NUM_ENGINES-1:0] bps_stall,
  input  logic [NUM_ENGINES-1:0] converged,
  output logic                   all_idle,
  output logic                   all_conv
);

  always_comb begin
    all_idle = ~|(bps_stall & mask);
    all_conv = &(converged | ~mask);
  end

endmodule

// File: rtl/bps_sequencer.sv
// Multi-engine BP-S master: LOAD, DOWN/UP pass pairs and final stores, plus single-op EXEC.
// Optional early exit on convergence is enabled by defining BPS_SEQ_CONVERGE_EN.
module bps_sequencer
  import bps_pkg::*;
#(
  parameter int unsigned NUM_ENGINES = 4,
  parameter int unsigned ITER_W      = 8,
  parameter int unsigned OPCODE_W    = OPCODE_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [OPCODE_W-1:0]    instruction,
  input  logic [ITER_W-1:0]      iterations,
  input  logic [NUM_ENGINES-1:0] engine_mask,
  input  logic                   abort,
  input  logic [NUM_ENGINES-1:0] converged,
  input  logic [NUM_ENGINES-1:0] bps_stall,
  output logic                   stall,
  output logic [OPCODE_W-1:0]    bps_opcode,
  output logic [NUM_ENGINES-1:0] bps_valid,
  output logic [ITER_W-1:0]      pass_count,
  output logic                   done
);

`ifdef BPS_SEQ_CONVERGE_EN
  localparam bit ConvEn = 1'b1;
`else
  localparam bit ConvEn = 1'b0;
`endif

  state_e                 state_q, state_d;
  logic [ITER_W-1:0]      count_q, count_d;
  logic [NUM_ENGINES-1:0] mask_q, mask_d;
  logic [ITER_W-1:0]      pass_q, pass_d;
  logic                   abort_q, abort_d;
  logic [OPCODE_W-1:0]    op_q, op_d;
  logic                   done_q, done_d;

  logic   all_idle, all_conv, abort_seen, in_wait, conv_cut;
  state_e w_next;

  bps_stall_agg #(
    .NUM_ENGINES(NUM_ENGINES)
  ) u_agg (
    .mask      (mask_q),
    .bps_stall (bps_stall),
    .converged (converged),
    .all_idle  (all_idle),
    .all_conv  (all_conv)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    mask_d     = mask_q;
    pass_d     = pass_q;
    abort_d    = abort_q;
    op_d       = op_q;
    done_d     = 1'b0;
    bps_opcode = '0;
    bps_valid  = '0;
    in_wait    = 1'b0;
    w_next     = S_IDLE;
    stall      = (state_q != S_IDLE);
    abort_seen = abort_q | abort;
    conv_cut   = ConvEn && all_conv && (count_q != '0);

    if (state_q != S_IDLE && abort) abort_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (start) begin
          state_d = S_LOAD;
          count_d = (iterations == '0) ? ITER_W'(1) : iterations;
          mask_d  = engine_mask;
          pass_d  = '0;
        end else if (instruction != '0) begin
          state_d = S_EXEC;
          op_d    = instruction;
          mask_d  = engine_mask;
        end
      end
      S_LOAD: begin
        bps_opcode = OPCODE_W'(OP_LOAD);
        bps_valid  = mask_q;
        state_d    = S_LOAD_W;
      end
      S_DOWN: begin
        bps_opcode = OPCODE_W'(OP_DOWN);
        bps_valid  = mask_q;
        state_d    = S_DOWN_W;
        // count may already be 0 after a convergence cut; hold it there
        if (count_q != '0) count_d = count_q - ITER_W'(1);
        if (pass_q != '1) pass_d = pass_q + ITER_W'(1);
      end
      S_ST_DN: begin
        bps_opcode = OPCODE_W'(OP_STORE_DN);
        bps_valid  = mask_q;
        state_d    = S_ST_DN_W;
      end
      S_UP: begin
        bps_opcode = OPCODE_W'(OP_UP);
        bps_valid  = mask_q;
        state_d    = S_UP_W;
      end
      S_ST_UP: begin
        bps_opcode = OPCODE_W'(OP_STORE_UP);
        bps_valid  = mask_q;
        state_d    = S_ST_UP_W;
      end
      S_EXEC: begin
        bps_opcode = op_q;
        bps_valid  = mask_q;
        state_d    = S_EXEC_W;
      end
      S_LOAD_W: begin
        in_wait = 1'b1;
        w_next  = S_DOWN;
      end
      S_DOWN_W: begin
        in_wait = 1'b1;
        w_next  = (count_q == '0) ? S_ST_DN : S_UP;
      end
      S_ST_DN_W: begin
        in_wait = 1'b1;
        w_next  = S_UP;
      end
      S_UP_W: begin
        in_wait = 1'b1;
        w_next  = (count_q == '0) ? S_ST_UP : S_DOWN;
      end
      S_ST_UP_W: begin
        in_wait = 1'b1;
        w_next  = S_IDLE;
      end
      S_EXEC_W: begin
        in_wait = 1'b1;
        w_next  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // All wait states share completion handling; abort overrides the normal successor
    if (in_wait && all_idle) begin
      if (abort_seen) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end else begin
        state_d = w_next;
        if (state_q == S_UP_W && conv_cut) count_d = '0;
        if (w_next == S_IDLE) done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      mask_q  <= '0;
      pass_q  <= '0;
      abort_q <= 1'b0;
      op_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mask_q  <= mask_d;
      pass_q  <= pass_d;
      abort_q <= abort_d;
      op_q    <= op_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    pass_count = pass_q;
    done       = done_q;
  end

endmodule

// File: tb/tb_bps_sequencer.sv
// Directed bench for bps_sequencer: expected opcode/mask trace queued at launch, popped per issue cycle.
module tb_bps_sequencer;

  localparam int NE = 4;
  localparam int IW = 8;
  localparam int OW = 3;

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic [OW-1:0] instruction;
  logic [IW-1:0] iterations;
  logic [NE-1:0] engine_mask, converged, bps_stall, force_stall;
  logic          stall, done;
  logic [OW-1:0] bps_opcode;
  logic [NE-1:0] bps_valid;
  logic [IW-1:0] pass_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [OW-1:0] op;
    logic [NE-1:0] mask;
  } exp_t;
  exp_t sb[$];

  logic [1:0] busy [NE];

  bps_sequencer #(
    .NUM_ENGINES(NE),
    .ITER_W     (IW),
    .OPCODE_W   (OW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .instruction(instruction),
    .iterations (iterations),
    .engine_mask(engine_mask),
    .abort      (abort),
    .converged  (converged),
    .bps_stall  (bps_stall),
    .stall      (stall),
    .bps_opcode (bps_opcode),
    .bps_valid  (bps_valid),
    .pass_count (pass_count),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Engine model: busy for 3 cycles after each valid issue
  always @(posedge clk) begin
    for (int i = 0; i < NE; i++) begin
      if (rst)               busy[i] <= 2'd0;
      else if (bps_valid[i]) busy[i] <= 2'd3;
      else if (busy[i] != 0) busy[i] <= busy[i] - 2'd1;
    end
  end

  always_comb begin
    bps_stall = '0;
    for (int i = 0; i < NE; i++) bps_stall[i] = (busy[i] != 2'd0) | force_stall[i];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_seq(input int n, input logic [NE-1:0] m);
    exp_t e;
    e.mask = m;
    e.op = 3'd1; sb.push_back(e);
    for (int k = 1; k <= n; k++) begin
      e.op = 3'd2; sb.push_back(e);
      if (k == n) begin e.op = 3'd4; sb.push_back(e); end
      e.op = 3'd3; sb.push_back(e);
      if (k == n) begin e.op = 3'd5; sb.push_back(e); end
    end
  endtask

  task automatic run_seq(input string tag, input int budget, input logic [OW-1:0] abort_op,
                         output int cycles);
    bit   seen_done = 0;
    bit   armed = 0;
    bit   fired = 0;
    exp_t e;
    cycles = 0;
    while (!seen_done && cycles < budget) begin
      @(negedge clk);
      cycles++;
      start       = 1'b0;
      instruction = '0;
      abort       = armed;
      armed       = 1'b0;
      if (bps_opcode != '0) begin
        if (sb.size() == 0) begin
          check({tag, "_extra_op"}, 32'(bps_opcode), 32'd0);
        end else begin
          e = sb.pop_front();
          check({tag, "_opcode"}, 32'(bps_opcode), 32'(e.op));
          check({tag, "_valid"}, 32'(bps_valid), 32'(e.mask));
          if (abort_op != '0 && e.op == abort_op && !fired) begin
            armed = 1'b1;
            fired = 1'b1;
          end
        end
      end
      if (done) begin
        seen_done = 1'b1;
        check({tag, "_stall_at_done"}, 32'(stall), 32'd0);
      end else begin
        check({tag, "_stall_busy"}, 32'(stall), 32'd1);
      end
    end
    abort = 1'b0;
    if (!seen_done) check({tag, "_timeout"}, 32'd0, 32'd1);
    check({tag, "_queue_empty"}, 32'(sb.size()), 32'd0);
    sb.delete();
    @(negedge clk);
    check({tag, "_done_single"}, 32'(done), 32'd0);
  endtask

  initial begin
    int   cyc;
    bit   found;
    exp_t e;
    rst = 1'b1; start = 1'b0; abort = 1'b0; instruction = '0;
    iterations = '0; engine_mask = '0; converged = '0; force_stall = '0;
    repeat (3) @(negedge clk);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_opcode", 32'(bps_opcode), 32'd0);
    check("rst_valid", 32'(bps_valid), 32'd0);
    check("rst_pass", 32'(pass_count), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // full mask, 2 iterations
    start = 1'b1; iterations = 8'd2; engine_mask = 4'b1111;
    push_seq(2, 4'b1111);
    run_seq("full2", 300, '0, cyc);
    check("full2_pass", 32'(pass_count), 32'd2);

    // engine 1 disabled and permanently stalled
    force_stall = 4'b0010;
    start = 1'b1; iterations = 8'd1; engine_mask = 4'b0101;
    push_seq(1, 4'b0101);
    run_seq("mask5", 300, '0, cyc);
    check("mask5_pass", 32'(pass_count), 32'd1);
    force_stall = '0;

    // zero iterations behaves as one
    start = 1'b1; iterations = 8'd0; engine_mask = 4'b1111;
    push_seq(1, 4'b1111);
    run_seq("iter0", 300, '0, cyc);
    check("iter0_pass", 32'(pass_count), 32'd1);

    // start beats instruction, then a single EXEC
    start = 1'b1; instruction = 3'd3; iterations = 8'd1; engine_mask = 4'b1111;
    push_seq(1, 4'b1111);
    run_seq("prio", 300, '0, cyc);
    instruction = 3'd4; engine_mask = 4'b0011;
    e.op = 3'd4; e.mask = 4'b0011; sb.push_back(e);
    run_seq("exec", 50, '0, cyc);
    check("exec_pass_kept", 32'(pass_count), 32'd1);

    // abort during first DOWN_W of 3 iterations
    start = 1'b1; iterations = 8'd3; engine_mask = 4'b1111;
    e.mask = 4'b1111;
    e.op = 3'd1; sb.push_back(e);
    e.op = 3'd2; sb.push_back(e);
    run_seq("abort", 300, 3'd2, cyc);
    check("abort_pass", 32'(pass_count), 32'd1);

    // empty mask: two cycles per op, ten states before done
    start = 1'b1; iterations = 8'd1; engine_mask = 4'b0000;
    push_seq(1, 4'b0000);
    run_seq("empty", 100, '0, cyc);
    check("empty_latency", 32'(cyc), 32'd11);

`ifdef BPS_SEQ_CONVERGE_EN
    converged = 4'b1111;
    start = 1'b1; iterations = 8'd10; engine_mask = 4'b1111;
    push_seq(2, 4'b1111);
    run_seq("conv", 400, '0, cyc);
    check("conv_pass", 32'(pass_count), 32'd2);
    converged = '0;
`endif

    // reset during DOWN_W
    start = 1'b1; iterations = 8'd2; engine_mask = 4'b1111;
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (bps_opcode == 3'd2) found = 1'b1;
    end
    check("rstmid_reached_down", 32'(found), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_stall", 32'(stall), 32'd0);
    check("rstmid_opcode", 32'(bps_opcode), 32'd0);
    check("rstmid_valid", 32'(bps_valid), 32'd0);
    check("rstmid_pass", 32'(pass_count), 32'd0);
    check("rstmid_done", 32'(done), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rstmid_no_done", 32'(done), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bps_sequencer.md
Name: bps_sequencer

Overview:
Parametrised successor of the single-engine BP-S master. It sequences LOAD, alternating DOWN/UP belief-propagation passes, and final STORE_DOWN/STORE_UP across NUM_ENGINES parallel BP-S engines, and also executes single host instructions. Over the single-engine master it adds per-engine enable masking, stall aggregation, pass-count visibility, abort and a done pulse. It sits between the host command interface and the engine array.

Parameters:
NUM_ENGINES, 4, number of BP-S engines driven in lockstep (1..32)
ITER_W, 8, width of the iteration count and pass counter
OPCODE_W, 3, width of the instruction and opcode buses

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  launch full sequence (sampled in IDLE only)
instruction  in  OPCODE_W  single-op request; nonzero in IDLE launches EXEC
iterations  in  ITER_W  DOWN/UP pass pairs; latched with start
engine_mask  in  NUM_ENGINES  engines taking part; latched with start or instruction
abort  in  1  terminate sequence at next wait completion
converged  in  NUM_ENGINES  per-engine convergence flag (used only with the optional feature)
bps_stall  in  NUM_ENGINES  per-engine busy
stall  out  1  master busy to host
bps_opcode  out  OPCODE_W  broadcast opcode; OP_IDLE=0 except in issue states
bps_valid  out  NUM_ENGINES  latched mask in issue states, else 0
pass_count  out  ITER_W  DOWN passes completed in current sequence
done  out  1  one-cycle pulse on return to IDLE

Behaviour:
- Interface: one clock, clk; reset rst is synchronous, active-high.
- Reset: state=IDLE, stall=0, bps_opcode=0, bps_valid=0, pass_count=0, done=0, internal count=0, mask=0.
- Opcodes: IDLE 0, LOAD 1, DOWN 2, UP 3, STORE_DOWN 4, STORE_UP 5.
- all_idle = ~|(bps_stall & mask). Disabled engines never block.
- States: IDLE, LOAD, LOAD_W, DOWN, DOWN_W, ST_DN, ST_DN_W, UP, UP_W, ST_UP, ST_UP_W, EXEC, EXEC_W.
- Issue states (LOAD, DOWN, ST_DN, UP, ST_UP, EXEC):
  - Last exactly 1 cycle.
  - Drive opcode and bps_valid=mask.
  - Always advance to the matching _W state.
  - Engines must raise stall in the cycle after issue.
  - _W states advance when all_idle, with the minimum stay being 1 cycle.
- IDLE:
  - start has priority over a nonzero instruction. start -> LOAD; latch count=max(iterations,1) (0 treated as 1); latch mask; clear pass_count.
  - Nonzero instruction -> EXEC; opcode registered at entry is issued in EXEC.
  - IDLE is the only state with stall=0.
- DOWN: count decrements; pass_count increments (saturating at all-ones).
- DOWN_W (all_idle): count==0 -> ST_DN, else UP.
- ST_DN_W -> UP.
- UP_W (all_idle): count==0 -> ST_UP, else DOWN.
- ST_UP_W -> IDLE.
- EXEC_W -> IDLE.
- Sequence with N iterations: LOAD, (DOWN,UP)xN, with STORE_DOWN inserted after the final DOWN and STORE_UP after the final UP. Host-visible passes = 2N.
- abort: sticky once seen in any non-IDLE state. At the next _W completion, go to IDLE with no stores issued. Cleared in IDLE.
- done: pulses in the cycle after entering IDLE from any _W state, including abort and EXEC.
- Empty latched mask: bps_valid all-zero, all_idle=1, sequence runs at minimum latency (2 cycles per op).
- rst mid-sequence: immediate return to reset values next edge; no done pulse.
- Instruction values >5 in EXEC are passed through unmodified.

Optional Feature:
Macro BPS_SEQ_CONVERGE_EN.
- Defined: in UP_W on completion, if &(converged | ~mask) and count!=0, force count=0 and go to DOWN. Only one more DOWN/STORE/UP/STORE tail follows. pass_count reflects the truncated run.
- Undefined: converged is ignored, and the full iteration count always runs.

Decomposition:
- Shared package bps_pkg: opcode localparams (OP_IDLE..OP_STORE_UP), state encoding (4-bit enum), OPCODE_W default.
- One natural sub-module: bps_stall_agg (mask & stall reduction, plus the converged reduction when enabled). All else lives in the top FSM.

Test Plan:
- NUM_ENGINES=4, mask=4'b1111, iterations=2, engines stall 3 cycles per op -> opcode trace 1,2,3,2,4,3,5; pass_count=2; single done pulse; stall low only after.
- mask=4'b0101, bps_stall[1]=1 held permanently -> sequence completes; disabled engine 1 ignored; bps_valid=4'b0101 in issue cycles.
- iterations=0 -> identical to iterations=1: trace 1,2,4,3,5; pass_count=1.
- start=1 and instruction=3 in same IDLE cycle -> LOAD wins. Later instruction=4 alone -> single opcode 4 for one cycle, then done.
- abort asserted during DOWN_W of iteration 1 of 3 -> no STORE opcodes; IDLE after all_idle; done pulse; pass_count=1.
- BPS_SEQ_CONVERGE_EN, iterations=10, converged all-ones after first UP -> trace 1,2,3,2,4,3,5; pass_count=2. Reset asserted mid-DOWN_W -> all outputs at reset values next cycle, no done.
